// File: rtl/mac_pkg.sv
// Shared constants for the MAC result serializer: parameter defaults and the
// serializer state encoding.
package mac_pkg;
   localparam int RES_W_DEF = 16;
   localparam int DEPTH_DEF = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
endpackage

// File: rtl/mac_res_fifo.sv
// Result FIFO: up to N pushes per cycle in ascending column order, one pop.
// Storage is not reset; only the wrap-around pointers are.
module mac_res_fifo
   import mac_pkg::*;
#(
   parameter int N     = 2,
   parameter int RES_W = RES_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [N-1:0]       push,
   input  logic [N*RES_W-1:0] din,
   input  logic               pop,
   output logic [RES_W-1:0]   head,
   output logic [7:0]         nxt_lo,
   output logic               empty,
   output logic               multi,
   output logic               drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [RES_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr, count, free, n_push;
   logic [AW-1:0]    waddr [N];
   logic [AW-1:0]    rd_nxt_a;
   logic [N-1:0]     acc;
   logic             full;

   assign count    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign multi    = (count > PW'(1));
   assign rd_nxt_a = rd_ptr[AW-1:0] + AW'(1);
   assign head     = mem[rd_ptr[AW-1:0]];
   assign nxt_lo   = mem[rd_nxt_a][7:0];

   // A same-cycle pop frees its entry, so it counts towards the free space.
   always_comb begin
      free   = full ? {{(PW-1){1'b0}}, pop}
                    : PW'(DEPTH) - count + {{(PW-1){1'b0}}, pop};
      n_push = '0;
      acc    = '0;
      drop   = 1'b0;
      for (int k = 0; k < N; k++) begin
         waddr[k] = wr_ptr[AW-1:0] + n_push[AW-1:0];
         if (push[k]) begin
            if (n_push < free) begin
               acc[k] = 1'b1;
               n_push = n_push + PW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + n_push;
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         for (int k = 0; k < N; k++) begin
            if (acc[k]) mem[waddr[k]] <= din[k*RES_W +: RES_W];
         end
      end
   end
endmodule

// File: rtl/mac_res_ser.sv
// Captures MAC column results into a FIFO and streams each word out as two
// bytes (low then high) over a valid/ready byte port.
//
//   state | meaning
//   IDLE  | nothing presented, waiting for a word in the FIFO
//   LO    | low byte of the head word presented
//   HI    | high byte of the head word presented; pops on accept
module mac_res_ser
   import mac_pkg::*;
#(
   parameter int N     = 2,
   parameter int RES_W = RES_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       res_wr_i,
   input  logic [N*RES_W-1:0] res_i,
   input  logic               out_rdy_i,
   input  logic               clr_i,
   output logic [7:0]         out_data_o,
   output logic               out_v_o,
   output logic               out_last_o,
   output logic               ovf_o
);
   localparam int NN = N * N;
   localparam int CW = (NN > 1) ? $clog2(NN) : 1;

   logic [1:0]       state;
   logic [CW-1:0]    wcnt;
   logic [RES_W-1:0] head;
   logic [7:0]       nxt_lo;
   logic             empty, multi, drop, pop, at_last;

   assign pop     = (state == ST_HI) && out_v_o && out_rdy_i && !clr_i;
   assign at_last = (wcnt == CW'(NN - 1));

   mac_res_fifo #(.N(N), .RES_W(RES_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_i),
      .push   (res_wr_i),
      .din    (res_i),
      .pop    (pop),
      .head   (head),
      .nxt_lo (nxt_lo),
      .empty  (empty),
      .multi  (multi),
      .drop   (drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         wcnt       <= '0;
         out_data_o <= '0;
         out_v_o    <= 1'b0;
         out_last_o <= 1'b0;
         ovf_o      <= 1'b0;
      end else if (clr_i) begin
         state      <= ST_IDLE;
         wcnt       <= '0;
         out_data_o <= '0;
         out_v_o    <= 1'b0;
         out_last_o <= 1'b0;
         ovf_o      <= 1'b0;
      end else begin
         if (drop) ovf_o <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  out_data_o <= head[7:0];
                  out_v_o    <= 1'b1;
                  state      <= ST_LO;
               end
            end
            ST_LO: begin
               if (out_v_o && out_rdy_i) begin
                  out_data_o <= head[15:8];
                  out_last_o <= at_last;
                  state      <= ST_HI;
               end
            end
            ST_HI: begin
               if (out_v_o && out_rdy_i) begin
                  wcnt       <= at_last ? '0 : wcnt + CW'(1);
                  out_last_o <= 1'b0;
                  // Only a word already stored behind the head can follow
                  // without a bubble; same-cycle pushes go through IDLE.
                  if (multi) begin
                     out_data_o <= nxt_lo;
                     state      <= ST_LO;
                  end else begin
                     out_v_o <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
